cra_diag_master: RTL and testbench

- Diagnostic initiator for the CRA microcode-address board, acting from the front-end side.
- Writes a CRAM diagnostic address by issuing diag functions 052 and 051 with data on the EBUS.
- Reads CRA state back by issuing diag read functions 140–147 and sampling the EBUS while the CRA drives it.
- Sits between the front-end command path and the EBUS/diag-function bus.

---
 rtl/cra_diag_master.sv | 194 +++++++++++++++++++
 tb/tb_cra_diag_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cra_diag_master.sv
// Front-end diagnostic initiator for the CRA board: writes the CRAM diag address
// (functions 052/051) and reads CRA state back via diag read functions 140-147.
module cra_diag_master #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [1:0]  cmdOp,
    input  logic [0:10] cmdAdr,
    input  logic [0:2]  cmdSel,
    output logic [0:8]  diagFunc,
    output logic        diagStrobe,
    output logic [0:35] ebusOut,
    output logic        ebusOutEn,
    input  logic [0:35] ebusIn,
    input  logic        craDriving,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [0:47] rspData,
    output logic        rspErr,
    output logic [2:0]  o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and payload is stable while valid.

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_SETUP  = 3'd1,
        S_W_STROBE = 3'd2,
        S_W_HOLD   = 3'd3,
        S_R_SETUP  = 3'd4,
        S_R_WAIT   = 3'd5,
        S_R_SAMPLE = 3'd6,
        S_RESP     = 3'd7
    } state_t;

    localparam logic [1:0] OP_SETADR  = 2'd0;
    localparam logic [1:0] OP_READALL = 2'd1;
    localparam logic [1:0] OP_READONE = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    localparam logic [0:8] F_ADR_HI  = 9'o052;
    localparam logic [0:8] F_ADR_LO  = 9'o051;
    localparam logic [0:8] F_RD_BASE = 9'o140;

    state_t      r_state;
    state_t      w_next;

    logic [0:10] r_adr;
    logic [2:0]  r_sel;
    logic        r_all;
    logic        r_phase;
    logic [2:0]  r_idx;
    logic [3:0]  r_wait;
    logic [0:47] r_rsp_data;
    logic        r_rsp_err;
    logic        r_rsp_valid;

    logic        w_in_write;
    logic        w_in_read;
    logic        w_last_fn;
    logic [2:0]  w_fn_idx;
    logic        w_unused;

    assign w_in_write = (r_state == S_W_SETUP) || (r_state == S_W_STROBE) ||
                        (r_state == S_W_HOLD);
    assign w_in_read  = (r_state == S_R_SETUP) || (r_state == S_R_WAIT) ||
                        (r_state == S_R_SAMPLE);
    assign w_last_fn  = !r_all || (r_idx == 3'd7);
    assign w_fn_idx   = r_all ? r_idx : r_sel;
    assign w_unused   = ^ebusIn[6:35];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmdValid) begin
                    case (cmdOp)
                        OP_SETADR:  w_next = S_W_SETUP;
                        OP_READALL: w_next = S_R_SETUP;
                        OP_READONE: w_next = S_R_SETUP;
                        default:    w_next = S_RESP;
                    endcase
                end
            end
            S_W_SETUP:  w_next = S_W_STROBE;
            S_W_STROBE: w_next = S_W_HOLD;
            S_W_HOLD:   w_next = r_phase ? S_RESP : S_W_SETUP;
            S_R_SETUP:  w_next = S_R_WAIT;
            S_R_WAIT:   w_next = (r_wait == 4'd0) ? S_R_SAMPLE : S_R_WAIT;
            S_R_SAMPLE: w_next = w_last_fn ? S_RESP : S_R_SETUP;
            S_RESP:     w_next = (r_rsp_valid && rspReady) ? S_IDLE : S_RESP;
            default:    w_next = S_IDLE;
        endcase
    end

    // Command latch, read sequencing and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_adr       <= '0;
            r_sel       <= '0;
            r_all       <= 1'b0;
            r_phase     <= 1'b0;
            r_idx       <= '0;
            r_wait      <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmdValid) begin
                        r_adr       <= cmdAdr;
                        r_sel       <= cmdSel;
                        r_all       <= (cmdOp == OP_READALL);
                        r_phase     <= 1'b0;
                        r_idx       <= '0;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= (cmdOp == OP_ILLEGAL);
                        r_rsp_valid <= (cmdOp == OP_ILLEGAL);
                    end
                end
                S_W_HOLD: begin
                    r_phase <= 1'b1;
                end
                S_R_SETUP: begin
                    r_wait <= 4'(SETTLE - 1);
                end
                S_R_WAIT: begin
                    r_wait <= r_wait - 4'd1;
                end
                S_R_SAMPLE: begin
                    if (r_all) begin
                        r_rsp_data[6*int'(r_idx) +: 6] <= ebusIn[0:5];
                    end else begin
                        r_rsp_data[42:47] <= ebusIn[0:5];
                    end
                    if (!craDriving) begin
                        r_rsp_err <= 1'b1;
                    end
                    if (w_last_fn) begin
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                S_RESP: begin
                    // After a write the first RESP cycle is a bus turnaround:
                    // the EBUS is released before the response is offered.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rspReady) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        cmdReady   = (r_state == S_IDLE);
        diagStrobe = (r_state == S_W_STROBE);
        ebusOutEn  = w_in_write;
        diagFunc   = '0;
        ebusOut    = '0;
        if (w_in_write) begin
            diagFunc = r_phase ? F_ADR_LO : F_ADR_HI;
            ebusOut  = r_phase ? {r_adr[5:10], 30'd0} : {1'b0, r_adr[0:4], 30'd0};
        end else if (w_in_read) begin
            diagFunc = F_RD_BASE + {6'd0, w_fn_idx};
        end
    end

    assign rspValid    = r_rsp_valid;
    assign rspData     = r_rsp_data;
    assign rspErr      = r_rsp_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cra_diag_master.sv
// Bench for cra_diag_master: scoreboarded write strobes, read function order and
// responses against a small EBUS model of the CRA.
module tb_cra_diag_master;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [0:10] cmdAdr;
  logic [0:2]  cmdSel;
  logic [0:8]  diagFunc;
  logic        diagStrobe;
  logic [0:35] ebusOut;
  logic        ebusOutEn;
  logic [0:35] ebusIn;
  logic        craDriving;
  logic        rspValid;
  logic        rspReady;
  logic [0:47] rspData;
  logic        rspErr;
  logic [2:0]  o_dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  int strobe_cnt = 0;

  logic [44:0] exp_q[$];
  logic [8:0]  exp_rd_q[$];
  logic [48:0] rsp_exp_q[$];

  logic [5:0] model_base;
  logic       model_step;
  logic [0:8] prev_func;
  logic       prev_strobe;

  cra_diag_master #(.SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdAdr(cmdAdr), .cmdSel(cmdSel), .diagFunc(diagFunc),
    .diagStrobe(diagStrobe), .ebusOut(ebusOut), .ebusOutEn(ebusOutEn),
    .ebusIn(ebusIn), .craDriving(craDriving), .rspValid(rspValid),
    .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // CRA model: returns field model_base (+n when stepping) for read function 140+n
  always_comb begin
    ebusIn = '0;
    if (!ebusOutEn && diagFunc >= 9'o140 && diagFunc <= 9'o147)
      ebusIn[0:5] = model_step ? model_base + 6'(diagFunc[6:8]) : model_base;
  end

  // bus monitor / scoreboard for strobes and read function order
  always @(negedge clk) begin
    if (!reset) begin
      if (diagStrobe) begin
        logic [44:0] e;
        strobe_cnt++;
        n_checks++;
        if (prev_strobe || !ebusOutEn)
          $display("FAIL strobe_shape: prev_strobe=%0b ebusOutEn=%0b required 0/1", prev_strobe, ebusOutEn);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL strobe_unexpected: func=%o data=%h required no strobe", diagFunc, ebusOut);
        end else begin
          e = exp_q.pop_front();
          if ({diagFunc, ebusOut} !== e)
            $display("FAIL strobe_data: func=%o data=%h required func=%o data=%h", diagFunc, ebusOut, e[44:36], e[35:0]);
          else n_pass++;
        end
      end
      if (ebusOutEn) begin
        n_checks++;
        if (diagFunc !== 9'o051 && diagFunc !== 9'o052)
          $display("FAIL ebus_en_func: func=%o required 051 or 052 while driving", diagFunc);
        else n_pass++;
      end
      if (!ebusOutEn && diagFunc !== 9'o000 && diagFunc !== prev_func) begin
        logic [8:0] f;
        n_checks++;
        if (exp_rd_q.size() == 0) begin
          $display("FAIL read_func_unexpected: func=%o required none", diagFunc);
        end else begin
          f = exp_rd_q.pop_front();
          if (diagFunc !== f) $display("FAIL read_func: func=%o required %o", diagFunc, f);
          else n_pass++;
        end
      end
      prev_func   = diagFunc;
      prev_strobe = diagStrobe;
    end
  end

  // driver tasks
  task automatic push_write(input int adr);
    logic [35:0] d;
    d = 36'((adr >> 6) & 31) << 30;
    exp_q.push_back({9'o052, d});
    d = 36'(adr & 63) << 30;
    exp_q.push_back({9'o051, d});
    rsp_exp_q.push_back({1'b0, 48'd0});
  endtask

  task automatic push_read(input logic [1:0] op, input int sel, input logic drv);
    logic [47:0] v;
    logic [5:0] fld;
    v = '0;
    if (op == 2'd1) begin
      for (int n = 0; n < 8; n++) begin
        exp_rd_q.push_back(9'(9'o140 + n));
        fld = model_step ? 6'((model_base + n) & 63) : model_base;
        v = v | (48'(fld) << (42 - 6 * n));
      end
    end else begin
      exp_rd_q.push_back(9'(9'o140 + sel));
      fld = model_step ? 6'((model_base + sel) & 63) : model_base;
      v = 48'(fld);
    end
    rsp_exp_q.push_back({!drv, v});
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [10:0] adr, input logic [2:0] sel);
    @(negedge clk);
    n_checks++;
    if (cmdReady !== 1'b1) $display("FAIL cmd_ready_idle: cmdReady=%0b required 1", cmdReady);
    else n_pass++;
    cmdValid = 1'b1; cmdOp = op; cmdAdr = adr; cmdSel = sel;
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rspValid !== 1'b1 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_rsp(input string name, input int lat, input int exp_lat);
    logic [48:0] e;
    n_checks++;
    if (lat !== exp_lat) $display("FAIL %s_latency: edges=%0d required %0d", name, lat, exp_lat);
    else n_pass++;
    n_checks++;
    if (rsp_exp_q.size() == 0) begin
      $display("FAIL %s_rsp_unexpected: err=%0b data=%o required no response", name, rspErr, rspData);
    end else begin
      e = rsp_exp_q.pop_front();
      if ({rspErr, rspData} !== e)
        $display("FAIL %s_rsp: err=%0b data=%o required err=%0b data=%o", name, rspErr, rspData, e[48], e[47:0]);
      else n_pass++;
    end
    // offer a new command in the consuming cycle; it must not be taken
    @(negedge clk);
    n_checks++;
    if (cmdReady !== 1'b0) $display("FAIL %s_ready_in_resp: cmdReady=%0b required 0", name, cmdReady);
    else n_pass++;
    rspReady = 1'b1; cmdValid = 1'b1; cmdOp = 2'd2;
    @(posedge clk);
    #1;
    rspReady = 1'b0; cmdValid = 1'b0;
    n_checks++;
    if (rspValid !== 1'b0 || cmdReady !== 1'b1)
      $display("FAIL %s_consume: rspValid=%0b cmdReady=%0b required 0/1", name, rspValid, cmdReady);
    else n_pass++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete(); exp_rd_q.delete(); rsp_exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (cmdReady !== 1'b1 || diagStrobe !== 1'b0 || ebusOutEn !== 1'b0 || rspValid !== 1'b0 || o_dbg_state !== 3'd0)
      $display("FAIL reset_abort: rdy=%0b stb=%0b en=%0b vld=%0b st=%0d required 1/0/0/0/0",
               cmdReady, diagStrobe, ebusOutEn, rspValid, o_dbg_state);
    else n_pass++;
  endtask

  task automatic do_setadr(input string name, input logic [10:0] adr);
    int lat, s0;
    s0 = strobe_cnt;
    push_write(int'(adr));
    send_cmd(2'd0, adr, 3'd0);
    wait_rsp(lat);
    n_checks++;
    if (ebusOutEn !== 1'b0 || diagFunc !== 9'o000)
      $display("FAIL %s_resp_bus: en=%0b func=%o required 0/000", name, ebusOutEn, diagFunc);
    else n_pass++;
    n_checks++;
    if (strobe_cnt - s0 !== 2) $display("FAIL %s_strobes: count=%0d required 2", name, strobe_cnt - s0);
    else n_pass++;
    finish_rsp(name, lat, 7);
  endtask

  task automatic do_read(input string name, input logic [1:0] op, input int sel, input logic drv);
    int lat, s0;
    s0 = strobe_cnt;
    craDriving = drv;
    push_read(op, sel, drv);
    send_cmd(op, 11'd0, 3'(sel));
    wait_rsp(lat);
    n_checks++;
    if (strobe_cnt !== s0) $display("FAIL %s_no_strobe: count=%0d required 0", name, strobe_cnt - s0);
    else n_pass++;
    finish_rsp(name, lat, (op == 2'd1) ? 8 * (SETTLE + 2) : SETTLE + 2);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (cmdReady !== 1'b1 || diagStrobe !== 1'b0 || ebusOutEn !== 1'b0 || diagFunc !== 9'd0 ||
        ebusOut !== 36'd0 || rspValid !== 1'b0 || rspData !== 48'd0 || rspErr !== 1'b0 || o_dbg_state !== 3'd0)
      $display("FAIL reset_state: rdy=%0b stb=%0b en=%0b func=%o out=%h vld=%0b data=%o err=%0b st=%0d required 1/0/0/0/0/0/0/0/0",
               cmdReady, diagStrobe, ebusOutEn, diagFunc, ebusOut, rspValid, rspData, rspErr, o_dbg_state);
    else n_pass++;
  endtask

  task automatic test_setadr();
    do_setadr("setadr_1777", 11'o1777);
    do_setadr("setadr_0123", 11'o0123);
    do_setadr("setadr_3777", 11'o3777);
  endtask

  task automatic test_readall();
    model_base = 6'o10; model_step = 1'b1;
    do_read("readall", 2'd1, 0, 1'b1);
  endtask

  task automatic test_readone_err();
    model_base = 6'o52; model_step = 1'b0;
    do_read("readone_err", 2'd2, 5, 1'b0);
  endtask

  task automatic test_illegal_hold();
    int lat, s0;
    s0 = strobe_cnt;
    rsp_exp_q.push_back({1'b1, 48'd0});
    send_cmd(2'd3, 11'o777, 3'd0);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (rspValid !== 1'b1 || rspErr !== 1'b1 || rspData !== 48'd0 || cmdReady !== 1'b0 ||
          ebusOutEn !== 1'b0 || o_dbg_state !== 3'd7)
        $display("FAIL illegal_hold: vld=%0b err=%0b data=%o rdy=%0b en=%0b st=%0d required 1/1/0/0/0/7",
                 rspValid, rspErr, rspData, cmdReady, ebusOutEn, o_dbg_state);
      else n_pass++;
      cmdValid = 1'b1; cmdOp = 2'd0; cmdAdr = 11'o1234;
    end
    @(negedge clk);
    cmdValid = 1'b0;
    n_checks++;
    if (strobe_cnt !== s0) $display("FAIL illegal_no_strobe: count=%0d required 0", strobe_cnt - s0);
    else n_pass++;
    finish_rsp("illegal", lat, 0);
  endtask

  task automatic test_reset_mid_write();
    push_write(int'(11'o1357));
    send_cmd(2'd0, 11'o1357, 3'd0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (diagStrobe !== 1'b1 || diagFunc !== 9'o051)
      $display("FAIL mid_write_pos: stb=%0b func=%o required 1/051", diagStrobe, diagFunc);
    else n_pass++;
    pulse_reset();
    do_setadr("after_write_reset", 11'o0456);
  endtask

  task automatic test_reset_mid_readall();
    model_base = 6'o20; model_step = 1'b1; craDriving = 1'b1;
    push_read(2'd1, 0, 1'b1);
    send_cmd(2'd1, 11'd0, 3'd0);
    repeat (10) @(posedge clk);
    pulse_reset();
    do_setadr("after_read_reset", 11'o2001);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 2));
      model_base = 6'($urandom_range(0, 63));
      model_step = 1'($urandom_range(0, 1));
      if (op == 2'd0) do_setadr("b2b_setadr", 11'($urandom_range(0, 2047)));
      else do_read("b2b_read", op, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1; cmdValid = 1'b0; cmdOp = '0; cmdAdr = '0; cmdSel = '0;
    rspReady = 1'b0; craDriving = 1'b1; model_base = '0; model_step = 1'b0;
    prev_func = '0; prev_strobe = 1'b0;
    test_reset();
    test_setadr();
    test_readall();
    test_readone_err();
    test_illegal_hold();
    test_reset_mid_write();
    test_reset_mid_readall();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || exp_rd_q.size() != 0 || rsp_exp_q.size() != 0)
      $display("FAIL leftover_expectations: strobes=%0d reads=%0d rsps=%0d required 0/0/0",
               exp_q.size(), exp_rd_q.size(), rsp_exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
